pow_n_pipe_hs: RTL and testbench

POW_N_PIPE_HS -- requirements
Module: pow_n_pipe_hs

---
 rtl/pow_pkg.sv | 18 +
 rtl/pow_stage.sv | 35 +++
 rtl/pow_n_pipe_hs.sv | 110 +++++++++++
 tb/tb_pow_n_pipe_hs.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pow_pkg.sv
// Shared constants and helpers for the pipelined integer power block.
package pow_pkg;

  localparam int POW_W_DEF  = 8;
  localparam int POW_N_DEF  = 5;
  localparam int POW_EW_DEF = 4;

  // Smallest r such that 2**r >= value; usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pow_stage.sv
// One multiply stage: folds another factor of the base into the partial power
// when this stage index is within the clamped exponent, else passes through.
module pow_stage
  import pow_pkg::*;
#(
  parameter int W     = POW_W_DEF,
  parameter int EW    = POW_EW_DEF,
  parameter int STAGE = 2
) (
  input  logic [W-1:0]  part_i,
  input  logic [W-1:0]  base_i,
  input  logic [EW-1:0] e_i,
  input  logic          ovf_i,
  output logic [W-1:0]  part_o,
  output logic          ovf_o
);

  localparam logic [EW-1:0] STAGE_E = EW'(STAGE);

  logic [2*W-1:0] prod;
  logic           active;

  always_comb begin
    prod   = (2*W)'(part_i) * (2*W)'(base_i);
    active = (STAGE_E <= e_i);
    part_o = part_i;
    ovf_o  = ovf_i;
    if (active) begin
      // Any bit above the result width means the true power no longer fits.
      part_o = prod[W-1:0];
      ovf_o  = ovf_i | (|prod[2*W-1:W]);
    end
  end

endmodule

// File: rtl/pow_n_pipe_hs.sv
// N-stage pipelined n^exp with valid/ready handshakes on both sides and a
// global clock enable; all stages shift in lock-step.
module pow_n_pipe_hs
  import pow_pkg::*;
#(
  parameter int W  = POW_W_DEF,
  parameter int N  = POW_N_DEF,
  parameter int EW = POW_EW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          arg_vld,
  output logic          arg_rdy,
  input  logic [W-1:0]  n,
  input  logic [EW-1:0] exp,
  output logic          res_vld,
  input  logic          res_rdy,
  output logic [W-1:0]  res,
  output logic          res_ovf,
  output logic          busy
);

  if (N < 2 || N > 8 || EW < clog2(N + 1)) begin : g_bad_params
    $error("pow_n_pipe_hs: N must be 2..8 and EW >= clog2(N+1)");
  end

  localparam logic [EW-1:0] N_E = EW'(N);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. arg_rdy is the pipeline advance itself, so it never depends on
  // arg_vld; res_vld/res/res_ovf hold until res_rdy is seen with clk_en high.
  logic                 advance;
  logic [EW-1:0]        e_clamp;

  logic [N-1:0]         vld_q, vld_d;
  logic [N-1:0]         ovf_q, ovf_d;
  logic [N-1:0][W-1:0]  base_q, base_d;
  logic [N-1:0][W-1:0]  part_q, part_d;
  logic [N-1:0][EW-1:0] e_q, e_d;

  logic [N-1:1][W-1:0]  mul_part;
  logic [N-1:1]         mul_ovf;
  logic                 unused_tail;

  assign advance = clk_en & (~vld_q[N-1] | res_rdy);
  assign arg_rdy = advance;
  assign e_clamp = (exp > N_E) ? N_E : exp;

  for (genvar k = 1; k < N; k++) begin : g_stage
    pow_stage #(
      .W    (W),
      .EW   (EW),
      .STAGE(k + 1)
    ) u_stage (
      .part_i(part_q[k-1]),
      .base_i(base_q[k-1]),
      .e_i   (e_q[k-1]),
      .ovf_i (ovf_q[k-1]),
      .part_o(mul_part[k]),
      .ovf_o (mul_ovf[k])
    );
  end

  always_comb begin
    vld_d     = '0;
    ovf_d     = '0;
    base_d    = '0;
    part_d    = '0;
    e_d       = '0;
    // Stage 1 loads every advancing cycle; a bubble simply carries valid=0.
    vld_d[0]  = arg_vld & arg_rdy;
    base_d[0] = n;
    e_d[0]    = e_clamp;
    part_d[0] = (e_clamp == '0) ? W'(1) : n;
    ovf_d[0]  = 1'b0;
    for (int k = 1; k < N; k++) begin
      vld_d[k]  = vld_q[k-1];
      base_d[k] = base_q[k-1];
      e_d[k]    = e_q[k-1];
      part_d[k] = mul_part[k];
      ovf_d[k]  = mul_ovf[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      ovf_q  <= '0;
      base_q <= '0;
      part_q <= '0;
      e_q    <= '0;
    end else if (advance) begin
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      base_q <= base_d;
      part_q <= part_d;
      e_q    <= e_d;
    end
  end

  assign res_vld = vld_q[N-1];
  assign res     = part_q[N-1];
  assign res_ovf = ovf_q[N-1];
  assign busy    = |vld_q;

  // The last stage keeps base/exponent for uniformity but nothing reads them.
  assign unused_tail = ^{base_q[N-1], e_q[N-1]};

endmodule

// File: tb/tb_pow_n_pipe_hs.sv
// Directed and randomized bench for pow_n_pipe_hs with a queue-based scoreboard
// fed by an arithmetic reference of n^min(exp,N).
module tb_pow_n_pipe_hs;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int EW = 4;

  logic          clk;
  logic          rst;
  logic          clk_en;
  logic          arg_vld;
  logic          arg_rdy;
  logic [W-1:0]  n;
  logic [EW-1:0] exp;
  logic          res_vld;
  logic          res_rdy;
  logic [W-1:0]  res;
  logic          res_ovf;
  logic          busy;

  int tests;
  int fails;
  int popped;
  logic [W:0] exp_q[$];

  pow_n_pipe_hs #(.W(W), .N(N), .EW(EW)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .arg_vld(arg_vld),
    .arg_rdy(arg_rdy),
    .n      (n),
    .exp    (exp),
    .res_vld(res_vld),
    .res_rdy(res_rdy),
    .res    (res),
    .res_ovf(res_ovf),
    .busy   (busy)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W:0] pow_model(input logic [W-1:0] b, input logic [EW-1:0] x);
    longint unsigned r;
    int e;
    logic [W-1:0] lo;
    r = 1;
    e = (int'(x) > N) ? N : int'(x);
    for (int i = 0; i < e; i++) r = r * longint'(b);
    lo = r[W-1:0];
    return {(r >= (64'd1 << W)), lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: values here decide what the next rising edge does.
  always @(negedge clk) begin
    logic [W:0] head;
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("arg_rdy_rule", arg_rdy, clk_en & (~res_vld | res_rdy));
      if (res_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          head = exp_q[0];
          chk("sb_res", res, head[W-1:0]);
          chk("sb_ovf", res_ovf, head[W]);
          if (res_rdy && clk_en) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      if (arg_vld && clk_en && (!res_vld || res_rdy))
        exp_q.push_back(pow_model(n, exp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drain(input string tag);
    int cyc;
    arg_vld = 1'b0;
    res_rdy = 1'b1;
    clk_en  = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_drain"}, (exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic single(input string tag, input logic [W-1:0] b, input logic [EW-1:0] x,
                        input logic [W-1:0] er, input logic eo);
    int cnt;
    res_rdy = 1'b1;
    clk_en  = 1'b1;
    n       = b;
    exp     = x;
    arg_vld = 1'b1;
    #1;
    chk({tag, "_rdy"}, arg_rdy, 1);
    @(posedge clk); #1;
    arg_vld = 1'b0;
    cnt = 1;
    while (!res_vld && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, cnt, N);
    chk({tag, "_res"}, res, er);
    chk({tag, "_ovf"}, res_ovf, eo);
    @(posedge clk); #1;
    chk({tag, "_one_cycle"}, res_vld, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx, cyc, cnt, stall_left, base_pop;
    logic seen, acc;
    tests = 0; fails = 0; popped = 0;
    rst = 1'b1; clk_en = 1'b1; arg_vld = 1'b0; res_rdy = 1'b1; n = '0; exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_vld", res_vld, 0);
    chk("rst_res", res, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("rst_arg_rdy", arg_rdy, 1);

    // single-token directed values
    single("p3e5", 8'd3, 4'd5, 8'hF3, 1'b0);
    single("p4e5", 8'd4, 4'd5, 8'h00, 1'b1);
    single("p2e5", 8'd2, 4'd5, 8'h20, 1'b0);
    single("p7e0", 8'd7, 4'd0, 8'h01, 1'b0);
    single("p7e1", 8'd7, 4'd1, 8'h07, 1'b0);
    single("p3e9", 8'd3, 4'd9, 8'hF3, 1'b0);
    drain("singles");

    // six back-to-back tokens with a 3-cycle output stall
    res_rdy = 1'b1; idx = 0; cyc = 0; seen = 1'b0; stall_left = 0; base_pop = popped;
    while (idx < 6 && cyc < 40) begin
      if (res_vld && !seen) begin
        seen = 1'b1;
        stall_left = 3;
      end
      res_rdy = (stall_left == 0);
      arg_vld = 1'b1;
      n       = W'(idx + 1);
      exp     = 4'd2;
      #1;
      if (stall_left > 0) begin
        chk("stall_arg_rdy", arg_rdy, 0);
        chk("stall_res_vld", res_vld, 1);
        chk("stall_res", res, 1);
        stall_left--;
      end
      acc = arg_rdy;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    chk("stall_all_sent", idx, 6);
    drain("stall");
    chk("stall_count", popped - base_pop, 6);

    // clock-enable freeze with two tokens in flight
    res_rdy = 1'b1; clk_en = 1'b1;
    n = 8'd5; exp = 4'd3; arg_vld = 1'b1;
    @(posedge clk); #1;
    n = 8'd6; exp = 4'd4;
    @(posedge clk); #1;
    arg_vld = 1'b0; cnt = 2;
    clk_en = 1'b0;
    #1;
    chk("frz_arg_rdy", arg_rdy, 0);
    repeat (3) begin
      @(posedge clk); #1;
      cnt++;
      chk("frz_busy", busy, 1);
      chk("frz_res_vld", res_vld, 0);
    end
    clk_en = 1'b1;
    while (!res_vld && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("frz_lat", cnt, N + 3);
    chk("frz_res0", res, 8'd125);
    chk("frz_ovf0", res_ovf, 0);
    @(posedge clk); #1;
    chk("frz_vld1", res_vld, 1);
    chk("frz_res1", res, 8'h10);
    chk("frz_ovf1", res_ovf, 1);
    drain("freeze");

    // reset with three tokens in flight, clk_en low to show reset still wins
    res_rdy = 1'b1; arg_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = W'(i + 2); exp = 4'd4;
      @(posedge clk); #1;
    end
    arg_vld = 1'b0; rst = 1'b1; clk_en = 1'b0;
    @(posedge clk); #1;
    chk("rstf_res_vld", res_vld, 0);
    chk("rstf_busy", busy, 0);
    chk("rstf_res", res, 0);
    chk("rstf_ovf", res_ovf, 0);
    rst = 1'b0; clk_en = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (res_vld || busy) cnt++;
    end
    chk("rstf_no_ghost", cnt, 0);
    chk("rstf_queue", exp_q.size(), 0);

    // randomized traffic with random backpressure and clock-enable gaps
    for (int i = 0; i < 400; i++) begin
      arg_vld = ($urandom_range(0, 3) != 0);
      n       = W'($urandom_range(0, 255));
      exp     = EW'($urandom_range(0, 15));
      res_rdy = ($urandom_range(0, 3) != 0);
      clk_en  = ($urandom_range(0, 7) != 0);
      @(posedge clk); #1;
    end
    drain("random");
    chk("random_results", (popped > 100), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
